// File: rtl/usb_ls_bit_tx_if.sv
// Byte-stream and pad-side signals of the low-speed USB bit transmitter.
// The master drives packet bytes in; the slave (transmitter) drives the pads and status.
interface usb_ls_bit_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_dp;
  logic       tx_dm;
  logic       tx_oe;
  logic       tx_busy;
  logic       tx_underrun;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, tx_dp, tx_dm, tx_oe, tx_busy, tx_underrun
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, tx_dp, tx_dm, tx_oe, tx_busy, tx_underrun
  );
endinterface

// File: rtl/usb_ls_bit_tx.sv
// Low-speed USB bit transmitter: SYNC, NRZI + bit-stuffed data LSB first, then EOP.
// Optional macro USB_TX_KEEPALIVE_EN adds keepalive_req for standalone EOPs from IDLE.
module usb_ls_bit_tx #(
  parameter int CLKS_PER_BIT = 32,
  parameter int STUFF_LEN    = 6
) (
  input logic clk,
  input logic rst,
`ifdef USB_TX_KEEPALIVE_EN
  input logic keepalive_req,
`endif
  usb_ls_bit_tx_if.slave tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic [7:0]      hold_q, hold_d;
  logic            holdFull_q, holdFull_d;
  logic            holdLast_q, holdLast_d;
  logic            shiftLast_q, shiftLast_d;
  logic            lastAcc_q, lastAcc_d;
  logic            alive_q;
  logic            dp_q, dp_d, dm_q, dm_d, oe_q, oe_d;
  logic            underrun_q, underrun_d;

  logic strobe, ready, accept, emit, emitBit;

  assign strobe = (cnt_q == CW'(CLKS_PER_BIT - 1));
  // alive_q keeps tx_ready low until the first clock after reset releases.
  assign ready  = alive_q && ((state_q == IDLE) ||
                  ((state_q == SYNC || state_q == DATA) && !holdFull_q && !lastAcc_q));
  assign accept = tx.tx_valid && ready;

  assign tx.tx_ready    = ready;
  assign tx.tx_dp       = dp_q;
  assign tx.tx_dm       = dm_q;
  assign tx.tx_oe       = oe_q;
  assign tx.tx_busy     = (state_q != IDLE);
  assign tx.tx_underrun = underrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bitIdx_q    <= '0;
      ones_q      <= '0;
      hold_q      <= '0;
      holdFull_q  <= 1'b0;
      holdLast_q  <= 1'b0;
      shiftLast_q <= 1'b0;
      lastAcc_q   <= 1'b0;
      alive_q     <= 1'b0;
      dp_q        <= 1'b0;
      dm_q        <= 1'b1;
      oe_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bitIdx_q    <= bitIdx_d;
      ones_q      <= ones_d;
      hold_q      <= hold_d;
      holdFull_q  <= holdFull_d;
      holdLast_q  <= holdLast_d;
      shiftLast_q <= shiftLast_d;
      lastAcc_q   <= lastAcc_d;
      alive_q     <= 1'b1;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      oe_q        <= oe_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == IDLE || strobe) ? '0 : cnt_q + 1'b1;
    shift_d     = shift_q;
    bitIdx_d    = bitIdx_q;
    ones_d      = ones_q;
    hold_d      = hold_q;
    holdFull_d  = holdFull_q;
    holdLast_d  = holdLast_q;
    shiftLast_d = shiftLast_q;
    lastAcc_d   = lastAcc_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    oe_d        = oe_q;
    underrun_d  = 1'b0;
    emit        = 1'b0;
    emitBit     = 1'b0;

    if (accept) begin
      hold_d     = tx.tx_data;
      holdFull_d = 1'b1;
      holdLast_d = tx.tx_last;
      lastAcc_d  = tx.tx_last;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SYNC;
          shift_d     = 8'h80;
          shiftLast_d = 1'b0;
          bitIdx_d    = '0;
          ones_d      = '0;
          oe_d        = 1'b1;
          emit        = 1'b1;
          emitBit     = 1'b0;
        end
`ifdef USB_TX_KEEPALIVE_EN
        else if (keepalive_req) begin
          state_d  = EOP_SE0;
          bitIdx_d = '0;
          oe_d     = 1'b1;
          dp_d     = 1'b0;
          dm_d     = 1'b0;
        end
`endif
      end
      SYNC, DATA: begin
        if (strobe) begin
          // A pending stuff bit takes priority, even after the final data bit.
          if (ones_q == OW'(STUFF_LEN)) begin
            emit = 1'b1;
          end else if (bitIdx_q != 3'd7) begin
            shift_d  = shift_q >> 1;
            bitIdx_d = bitIdx_q + 3'd1;
            emit     = 1'b1;
            emitBit  = shift_q[1];
          end else if (state_q == DATA && shiftLast_q) begin
            state_d  = EOP_SE0;
            bitIdx_d = '0;
            dp_d     = 1'b0;
            dm_d     = 1'b0;
          end else if (holdFull_q) begin
            state_d     = DATA;
            shift_d     = hold_q;
            shiftLast_d = holdLast_q;
            holdFull_d  = 1'b0;
            bitIdx_d    = '0;
            emit        = 1'b1;
            emitBit     = hold_q[0];
          end else if (accept) begin
            state_d     = DATA;
            shift_d     = tx.tx_data;
            shiftLast_d = tx.tx_last;
            holdFull_d  = 1'b0;
            bitIdx_d    = '0;
            emit        = 1'b1;
            emitBit     = tx.tx_data[0];
          end else begin
            state_d    = EOP_SE0;
            bitIdx_d   = '0;
            underrun_d = 1'b1;
            dp_d       = 1'b0;
            dm_d       = 1'b0;
          end
        end
      end
      EOP_SE0: begin
        if (strobe) begin
          if (bitIdx_q == 3'd1) begin
            state_d = EOP_J;
            dp_d    = 1'b0;
            dm_d    = 1'b1;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (strobe) begin
          state_d    = IDLE;
          oe_d       = 1'b0;
          holdFull_d = 1'b0;
          lastAcc_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI: a 0 (or stuff bit) toggles J<->K and breaks the run of ones.
    if (emit) begin
      if (!emitBit) begin
        dp_d   = ~dp_q;
        dm_d   = ~dm_q;
        ones_d = '0;
      end else begin
        ones_d = ones_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_usb_ls_bit_tx.sv
// Scoreboard bench for usb_ls_bit_tx: expected line symbols are queued per packet
// and a monitor compares each bit time (first and last clock) as the DUT transmits.
module tb_usb_ls_bit_tx;
  localparam int BIT_CLKS = 32;

  logic clk;
  logic rst;
`ifdef USB_TX_KEEPALIVE_EN
  logic keepaliveReq;
`endif

  usb_ls_bit_tx_if bus();

  usb_ls_bit_tx #(.CLKS_PER_BIT(BIT_CLKS), .STUFF_LEN(6)) dut (
    .clk(clk),
    .rst(rst),
`ifdef USB_TX_KEEPALIVE_EN
    .keepalive_req(keepaliveReq),
`endif
    .tx(bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;

  byte expQ[$];
  int  lenQ[$];
  int  urQ[$];

  int   pktDone   = 0;
  bit   monIgnore = 1'b0;
  int   k         = 0;
  int   urSeen    = 0;
  byte  cur       = "?";

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic byte lineSym(input logic dp, input logic dm);
    if (dp && !dm) return "K";
    if (!dp && dm) return "J";
    if (!dp && !dm) return "0";
    return "X";
  endfunction

  task automatic pushExpect(input string s, input int ur);
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    lenQ.push_back(s.len() * BIT_CLKS);
    urQ.push_back(ur);
  endtask

  // Monitor: samples on the falling edge, away from the active clock edge.
  always @(negedge clk) begin
    if (monIgnore) begin
      k      = 0;
      urSeen = 0;
    end else if (bus.tx_oe) begin
      if (k == 0) checkOutput("busy_at_start", {31'd0, bus.tx_busy}, 32'd1);
      if (k % BIT_CLKS == 0) begin
        if (expQ.size() == 0) begin
          cur = "?";
          checkOutput("line_extra_bit", k, 32'hFFFF_FFFF);
        end else begin
          cur = expQ.pop_front();
          checkOutput($sformatf("line_bit%0d_start", k / BIT_CLKS),
                      {24'd0, lineSym(bus.tx_dp, bus.tx_dm)}, {24'd0, cur});
        end
      end
      if (k % BIT_CLKS == BIT_CLKS - 1)
        checkOutput($sformatf("line_bit%0d_end", k / BIT_CLKS),
                    {24'd0, lineSym(bus.tx_dp, bus.tx_dm)}, {24'd0, cur});
      if (bus.tx_underrun) urSeen++;
      k++;
    end else if (k != 0) begin
      checkOutput("oe_length", k, (lenQ.size() != 0) ? lenQ.pop_front() : -1);
      checkOutput("underrun_count", urSeen, (urQ.size() != 0) ? urQ.pop_front() : -1);
      checkOutput("busy_falls_with_oe", {31'd0, bus.tx_busy}, 32'd0);
      checkOutput("line_idle_j", {24'd0, lineSym(bus.tx_dp, bus.tx_dm)}, {24'd0, 8'("J")});
      k      = 0;
      urSeen = 0;
      pktDone++;
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic last);
    int n;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = data;
    bus.tx_last  = last;
    n = 0;
    while (!bus.tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) checkOutput("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic waitPackets(input int target);
    int n;
    n = 0;
    while (pktDone < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (pktDone < target) checkOutput("packet_timeout", pktDone, target);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
`ifdef USB_TX_KEEPALIVE_EN
    keepaliveReq = 1'b0;
`endif
    #1;
    checkOutput("rst_oe", {31'd0, bus.tx_oe}, 32'd0);
    checkOutput("rst_dp", {31'd0, bus.tx_dp}, 32'd0);
    checkOutput("rst_dm", {31'd0, bus.tx_dm}, 32'd1);
    checkOutput("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, bus.tx_ready}, 32'd0);
    checkOutput("rst_underrun", {31'd0, bus.tx_underrun}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("ready_before_first_clk", {31'd0, bus.tx_ready}, 32'd0);
    @(posedge clk);
    #1 checkOutput("ready_after_first_clk", {31'd0, bus.tx_ready}, 32'd1);

    pushExpect("KJKJKJKKJKJKJKJK00J", 0);
    applyStimulus(8'h00, 1'b1);
    @(negedge clk);
    checkOutput("ready_low_after_last", {31'd0, bus.tx_ready}, 32'd0);
    waitPackets(1);

    pushExpect("KJKJKJKKKKKKKJJJJ00J", 0);
    applyStimulus(8'hFF, 1'b1);
    waitPackets(2);

    pushExpect("KJKJKJKKKJJKJJKKJKKKKKJK00J", 0);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h3C, 1'b1);
    @(negedge clk);
    checkOutput("ready_low_after_3c_last", {31'd0, bus.tx_ready}, 32'd0);
    waitPackets(3);

    pushExpect("KJKJKJKKJKKKKKKKJ00J", 0);
    applyStimulus(8'hFC, 1'b1);
    waitPackets(4);

    pushExpect("KJKJKJKKKJKJKJKJ00J", 1);
    applyStimulus(8'h01, 1'b0);
    waitPackets(5);

    monIgnore = 1'b1;
    applyStimulus(8'h00, 1'b1);
    repeat (12 * BIT_CLKS) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_oe", {31'd0, bus.tx_oe}, 32'd0);
    checkOutput("midrst_dp", {31'd0, bus.tx_dp}, 32'd0);
    checkOutput("midrst_dm", {31'd0, bus.tx_dm}, 32'd1);
    checkOutput("midrst_busy", {31'd0, bus.tx_busy}, 32'd0);
    checkOutput("midrst_ready", {31'd0, bus.tx_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    monIgnore = 1'b0;
    #1 checkOutput("midrst_ready_before_clk", {31'd0, bus.tx_ready}, 32'd0);
    @(posedge clk);
    #1 checkOutput("midrst_ready_after_clk", {31'd0, bus.tx_ready}, 32'd1);

    pushExpect("KJKJKJKKJKKKKKJK00J", 0);
    applyStimulus(8'h3C, 1'b1);
    waitPackets(6);

`ifdef USB_TX_KEEPALIVE_EN
    pushExpect("00J", 0);
    @(negedge clk);
    keepaliveReq = 1'b1;
    @(negedge clk);
    keepaliveReq = 1'b0;
    checkOutput("keepalive_ready", {31'd0, bus.tx_ready}, 32'd0);
    waitPackets(7);
`endif

    checkOutput("exp_queue_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
